gpr_scan_display: RTL
=====================

Name: gpr_scan_display

Overview:
Read-side counterpart to the board-side GPR write path. It sequences through a bank of GPRs and asserts one read-enable (RA-style) at a time. It captures the value driven on A_bus and drives active-low 7-segment patterns to show the register index and its 16-bit contents on the DE2-115 HEX displays. Scanning is either automatic, with a fixed dwell per register, or single-stepped from a pushbutton pulse.

Parameters:
NUM_REGS, 8, number of GPRs scanned; legal range 2..16; IDX_W = clog2(NUM_REGS)
DWELL, 50000000, HOLD cycles per register in auto mode (1 s at 50 MHz); must be >= 1
WIDTH, 16, A_bus width; fixed at 16 (four hex digits)

Ports:
CLK  in  1  system clock; all state changes on rising edge
CLR  in  1  synchronous reset, active-low; sampled on the CLK rising edge
RUN  in  1  1 = auto-scan, 0 = manual (step only); active-high (board wrapper inverts)
STEP  in  1  manual advance request, active-high level; rising edge detected internally
A_bus  in  16  data driven by the selected GPR, combinational from RA
RA_sel  out  NUM_REGS  one-hot register read enable; all-zero when not reading
reg_idx  out  IDX_W  index of the register currently shown
valid  out  1  1 once HOLD is entered; stays 1 through subsequent SELECT/CAPTURE; cleared only by CLR
HEX0..HEX3  out  7 each  hex digits of the captured value, HEX0 = bits[3:0]; active-low, bit6=g .. bit0=a
HEX4  out  7  hex digit of reg_idx (low 4 bits); active-low

Behaviour:
- Reset (CLR=0 at a clock edge):
  - state=SELECT, reg_idx=0, RA_sel=0, shadow=0, dwell counter=0, STEP edge register=0, valid=0.
  - HEX0..HEX4 = 7'b1000000 ("0").
  - Reset has priority over every other event, including mid-CAPTURE; no partial capture survives.
- FSM states: SELECT -> CAPTURE -> HOLD -> SELECT.
  - SELECT (1 cycle): RA_sel = one-hot(reg_idx).
  - CAPTURE (1 cycle): RA_sel held. On the exit edge, shadow <= A_bus and valid <= 1. Next state is HOLD.
  - HOLD: RA_sel = 0; HEX0..3 decode shadow and HEX4 decodes reg_idx.
- Advance condition in HOLD, when either holds:
  - RUN=1 and the dwell counter reaches DWELL-1, or
  - a STEP rising edge is seen (STEP=1 and its previous sampled value was 0).
- On advance:
  - reg_idx <= (reg_idx == NUM_REGS-1) ? 0 : reg_idx+1
  - dwell counter <= 0
  - state <= SELECT
- Dwell and step rules:
  - The dwell counter increments only in HOLD with RUN=1; it clears to 0 whenever RUN=0 or on leaving HOLD.
  - Simultaneous dwell expiry and STEP edge: exactly one advance.
  - STEP edges arriving in SELECT or CAPTURE are discarded (the edge register still updates every cycle).
  - Holding STEP high produces exactly one advance.
- Latency and display timing:
  - Capture-to-display latency is one cycle: HEX outputs are registered from shadow, so they update on the cycle after HOLD entry.
  - HEX outputs keep the previous value during SELECT/CAPTURE. No blanking or flicker is allowed.
- RA_sel is never multi-hot; every bit is 0 outside SELECT/CAPTURE.
- Segment encoding (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

Test Plan:
- Reset: hold CLR=0 for 3 cycles with arbitrary A_bus -> RA_sel=0, reg_idx=0, valid=0, HEX0..HEX4=1000000; release -> RA_sel=8'b00000001 for exactly 2 cycles.
- Capture: model GPR0=16'hA5F0; after release -> HEX3=0001000 (A), HEX2=0010010 (5), HEX1=0001110 (F), HEX0=1000000 (0), valid=1.
- Auto-scan with DWELL=4, RUN=1, GPRn=16'h1111*n: reg_idx steps every 6 cycles (2 read + 4 dwell) through 0..7, then wraps to 0; HEX4 tracks the index; RA_sel stays one-hot.
- Manual mode, RUN=0: no advance in 1000 cycles; a STEP pulse held high 10 cycles -> exactly one advance; a STEP edge during CAPTURE -> no advance.
- Simultaneous events, DWELL=4: STEP rising on the dwell-expiry cycle -> reg_idx advances by 1 only; RUN dropped mid-dwell then re-raised -> full 4-cycle dwell restarts.
- Reset mid-operation: CLR=0 during CAPTURE of reg 5 -> shadow=0, reg_idx=0, valid=0; the first RA_sel after release targets reg 0.

Source files
------------

// File: rtl/gpr_scan_display_if.sv
// Read-side GPR bus between the scan/display block and the GPR bank.
// The scanner drives the one-hot read enable and the board displays.
// The GPR bank answers combinationally on A_bus.
interface gpr_scan_display_if #(
  parameter int NUM_REGS = 8,
  parameter int WIDTH    = 16
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [WIDTH-1:0]    A_bus;
  logic [NUM_REGS-1:0] RA_sel;
  logic [IDX_W-1:0]    reg_idx;
  logic                valid;
  logic [6:0]          HEX0;
  logic [6:0]          HEX1;
  logic [6:0]          HEX2;
  logic [6:0]          HEX3;
  logic [6:0]          HEX4;

  // Scanner side: reads A_bus, drives selects and displays.
  modport master (
    input  A_bus,
    output RA_sel, reg_idx, valid, HEX0, HEX1, HEX2, HEX3, HEX4
  );

  // GPR bank / board side: answers A_bus, observes the rest.
  modport slave (
    output A_bus,
    input  RA_sel, reg_idx, valid, HEX0, HEX1, HEX2, HEX3, HEX4
  );
endinterface

// File: rtl/gpr_scan_display.sv
// GPR scan display: walks the GPR bank one register at a time.
// Each register gets a one-hot read enable for SELECT and CAPTURE.
// The returned value is latched into a shadow register.
// The register index and its value are shown on active-low 7-segment digits.
// Advance is automatic after a fixed dwell, or driven by STEP rising edges.
module gpr_scan_display #(
  parameter int NUM_REGS = 8,
  parameter int DWELL    = 50000000,
  parameter int WIDTH    = 16
) (
  input  logic CLK,
  input  logic CLR,
  input  logic RUN,
  input  logic STEP,
  gpr_scan_display_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REGS - 1);
  localparam logic [6:0]       SEG_ZERO   = 7'b1000000;

  typedef enum logic [1:0] {
    SELECT  = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_next;
  logic [CNT_W-1:0]    dwell_cnt;
  logic [CNT_W-1:0]    dwell_next;
  logic [WIDTH-1:0]    shadow;
  logic                step_prev;
  logic                step_edge;
  logic                dwell_done;
  logic                advance;
  logic                valid_flag;
  logic [NUM_REGS-1:0] ra_sel;
  logic [6:0]          hex0;
  logic [6:0]          hex1;
  logic [6:0]          hex2;
  logic [6:0]          hex3;
  logic [6:0]          hex4;

  // Active-low 7-segment pattern for one hex nibble, bit6=g .. bit0=a.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // State register; reset restarts the scan at SELECT.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state <= SELECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: fixed one-cycle SELECT and CAPTURE, HOLD until advance.
  always_comb begin
    state_next = state;
    case (state)
      SELECT:  state_next = CAPTURE;
      CAPTURE: state_next = HOLD;
      HOLD: begin
        if (advance) begin
          state_next = SELECT;
        end else begin
          state_next = HOLD;
        end
      end
      default: state_next = SELECT;
    endcase
  end

  // Control outputs: advance decision, dwell counter update, and read enable.
  // STEP edges outside HOLD are dropped because advance is qualified by HOLD.
  // A simultaneous dwell expiry and STEP edge still produce one advance.
  // The read enable is gated by CLR so the bus is released while reset is held.
  always_comb begin
    step_edge  = STEP & ~step_prev;
    dwell_done = RUN & (dwell_cnt == DWELL_LAST);
    advance    = (state == HOLD) & (dwell_done | step_edge);

    if (idx == IDX_LAST) begin
      idx_next = '0;
    end else begin
      idx_next = idx + IDX_W'(1);
    end

    if ((state == HOLD) && RUN && !advance) begin
      dwell_next = dwell_cnt + CNT_W'(1);
    end else begin
      dwell_next = '0;
    end

    ra_sel = '0;
    if (CLR && ((state == SELECT) || (state == CAPTURE))) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        ra_sel[i] = (idx == IDX_W'(i));
      end
    end else begin
      ra_sel = '0;
    end
  end

  // Scan position, dwell counter and STEP edge history.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      idx       <= '0;
      dwell_cnt <= '0;
      step_prev <= 1'b0;
    end else begin
      step_prev <= STEP;
      dwell_cnt <= dwell_next;
      if (advance) begin
        idx <= idx_next;
      end else begin
        idx <= idx;
      end
    end
  end

  // Latch A_bus on the CAPTURE exit edge; valid stays set until reset.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      shadow     <= '0;
      valid_flag <= 1'b0;
    end else if (state == CAPTURE) begin
      shadow     <= bus.A_bus;
      valid_flag <= 1'b1;
    end else begin
      shadow     <= shadow;
      valid_flag <= valid_flag;
    end
  end

  // Display registers refresh only in HOLD.
  // The digits therefore keep showing the previous register through SELECT and CAPTURE.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      hex0 <= SEG_ZERO;
      hex1 <= SEG_ZERO;
      hex2 <= SEG_ZERO;
      hex3 <= SEG_ZERO;
      hex4 <= SEG_ZERO;
    end else if (state == HOLD) begin
      hex0 <= seg7(shadow[3:0]);
      hex1 <= seg7(shadow[7:4]);
      hex2 <= seg7(shadow[11:8]);
      hex3 <= seg7(shadow[15:12]);
      hex4 <= seg7(4'(idx));
    end else begin
      hex0 <= hex0;
      hex1 <= hex1;
      hex2 <= hex2;
      hex3 <= hex3;
      hex4 <= hex4;
    end
  end

  assign bus.RA_sel  = ra_sel;
  assign bus.reg_idx = idx;
  assign bus.valid   = valid_flag;
  assign bus.HEX0    = hex0;
  assign bus.HEX1    = hex1;
  assign bus.HEX2    = hex2;
  assign bus.HEX3    = hex3;
  assign bus.HEX4    = hex4;

endmodule
